// File: rtl/upper_layer_tx_arbiter.sv
// Round-robin, burst-limited arbiter sharing the transport-to-logical-layer byte lane.
// Optional per-requester byte statistics are enabled with `define UL_ARB_STATS_EN.
module upper_layer_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_GAP     = 2,
  parameter logic [2:0] ACTIVE_PHASE = 3'd4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 phase,
  input  logic                       ll_ready,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 transport_layer_data_in,
  output logic                       enable_sending,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       abort
`ifdef UL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      byte_count,
  input  logic                       stats_clr
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_GAP} state_t;

  state_t          state;
  logic [7:0]      byte_cnt;
  logic [3:0]      gap_cnt;
  logic            phase_ok;
  logic            xfer;
  logic            burst_end;
  logic            arb_found;
  logic [ID_W-1:0] arb_idx;
  logic [7:0]      grant_byte;
  logic            vld_p1;
  logic [7:0]      data_p1;

  assign phase_ok   = (phase == ACTIVE_PHASE);
  assign grant_byte = req_data[{grant_id, 3'b000} +: 8];
  assign xfer       = (state == S_SEND) && phase_ok && ll_ready && req_valid[grant_id];
  assign burst_end  = xfer && (req_last[grant_id] ||
                               (({1'b0, byte_cnt} + 9'd1) == 9'(MAX_BURST)));

  // Ready is qualified by phase in the same cycle so a phase drop never accepts a byte.
  always_comb begin
    req_ready = '0;
    if ((state == S_SEND) && phase_ok)
      req_ready[grant_id] = ll_ready;
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = grant_id;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!arb_found && req_valid[ID_W'((int'(grant_id) + k) % NUM_REQ)]) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'((int'(grant_id) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      grant_id <= ID_W'(NUM_REQ - 1);
      byte_cnt <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (phase_ok && |req_valid) begin
            state <= S_ARB;
            busy  <= 1'b1;
          end
        end
        S_ARB: begin
          if (!phase_ok || !arb_found) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            grant_id <= arb_idx;
            byte_cnt <= '0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (!phase_ok) begin
            // Any burst still in SEND has not yet taken its last byte.
            abort <= (byte_cnt != 8'd0);
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (xfer) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (burst_end) begin
              gap_cnt <= '0;
              state   <= (IDLE_GAP > 0) ? S_GAP : S_ARB;
            end
          end
        end
        S_GAP: begin
          if (!phase_ok) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == 4'(IDLE_GAP - 1)) begin
            state <= S_ARB;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: accepted byte appears one cycle after the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= 8'h00;
    end else begin
      vld_p1 <= xfer;
      if (xfer)
        data_p1 <= grant_byte;
    end
  end

  assign enable_sending          = vld_p1;
  assign transport_layer_data_in = data_p1;

`ifdef UL_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++)
        stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)
          stat_cnt[i] <= '0;
        else if (xfer && (grant_id == ID_W'(i)) && (stat_cnt[i] != 16'hFFFF))
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte_count
    assign byte_count[16*g +: 16] = stat_cnt[g];
  end
`endif

endmodule

// File: tb/tb_upper_layer_tx_arbiter.sv
// Bench for upper_layer_tx_arbiter: two instances (burst cap 64 and 4) share one stimulus
// and are both tracked by a cycle-stamp reference model; directed sequences cover corner cases.
module tb_upper_layer_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     phase;
  logic           ll_ready;
  logic [N-1:0]   req_valid, req_last;
  logic [N*8-1:0] req_data;
  logic           stats_clr;

  logic [N-1:0]   rdy  [2];
  logic [7:0]     dout [2];
  logic           en   [2];
  logic [1:0]     gid  [2];
  logic           bsy  [2];
  logic           abt  [2];
`ifdef UL_ARB_STATS_EN
  logic [N*16-1:0] bc  [2];
`endif

  upper_layer_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(64), .IDLE_GAP(GAP), .ACTIVE_PHASE(3'd4)) u_dut (
    .clk(clk), .reset(reset), .phase(phase), .ll_ready(ll_ready),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(rdy[0]),
    .transport_layer_data_in(dout[0]), .enable_sending(en[0]), .grant_id(gid[0]),
    .busy(bsy[0]), .abort(abt[0])
`ifdef UL_ARB_STATS_EN
    , .byte_count(bc[0]), .stats_clr(stats_clr)
`endif
  );

  upper_layer_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4), .IDLE_GAP(GAP), .ACTIVE_PHASE(3'd4)) u_cap (
    .clk(clk), .reset(reset), .phase(phase), .ll_ready(ll_ready),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(rdy[1]),
    .transport_layer_data_in(dout[1]), .enable_sending(en[1]), .grant_id(gid[1]),
    .busy(bsy[1]), .abort(abt[1])
`ifdef UL_ARB_STATS_EN
    , .byte_count(bc[1]), .stats_clr(stats_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int sel     = 0;

  // Reference model: owner of the lane (-1 = none) and the cycle stamp of the next arbitration.
  int         owner [2], rr [2], sent [2], arb_at [2];
  logic       m_en [2], m_abort [2];
  logic [7:0] m_data [2];

  logic [N-1:0] s_ready;
  logic         s_en, s_busy, s_abort;
  logic [7:0]   s_data;
  logic [1:0]   s_gid;

  // Directed requester sources and output logs.
  int   pos [N], pkt [N], total [N];
  logic on [N];
  int   oc [$], acc [$];
  logic [7:0] od [$];

  typedef struct {
    logic [2:0] ph; logic v; logic [7:0] d; logic l; logic ll;
    logic e_r; logic e_en; logic [7:0] e_d; logic e_busy; logic [1:0] e_gid;
  } row_t;
  row_t tbl [11];

  function automatic int maxb(input int m);
    return (m == 0) ? 64 : 4;
  endfunction

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, m, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1; rr[m] = N - 1; sent[m] = 0; arb_at[m] = -1;
      m_en[m] = 1'b0; m_abort[m] = 1'b0; m_data[m] = 8'h00;
    end
  endtask

  task automatic model_step(input int m);
    logic pok;
    logic [N-1:0] er;
    int w;
    int j;
    pok = (phase == 3'd4);
    er  = '0;
    if (owner[m] >= 0 && pok && ll_ready) er[owner[m]] = 1'b1;
    chk("req_ready", m, 32'(rdy[m]), 32'(er));
    chk("enable_sending", m, 32'(en[m]), 32'(m_en[m]));
    chk("data", m, 32'(dout[m]), 32'(m_data[m]));
    chk("grant_id", m, 32'(gid[m]), rr[m]);
    chk("busy", m, 32'(bsy[m]), 32'(owner[m] >= 0 || arb_at[m] >= 0));
    chk("abort", m, 32'(abt[m]), 32'(m_abort[m]));
    m_en[m] = 1'b0;
    m_abort[m] = 1'b0;
    if (owner[m] >= 0) begin
      if (!pok) begin
        m_abort[m] = (sent[m] > 0);
        owner[m] = -1; arb_at[m] = -1;
      end else if (ll_ready && req_valid[owner[m]]) begin
        m_en[m] = 1'b1;
        m_data[m] = req_data[owner[m]*8 +: 8];
        sent[m]++;
        if (req_last[owner[m]] || sent[m] == maxb(m)) begin
          owner[m] = -1; arb_at[m] = cyc + 1 + GAP;
        end
      end
    end else if (arb_at[m] == cyc) begin
      arb_at[m] = -1;
      if (pok) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          j = (rr[m] + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
        if (w >= 0) begin owner[m] = w; rr[m] = w; sent[m] = 0; end
      end
    end else if (arb_at[m] > cyc) begin
      if (!pok) arb_at[m] = -1;
    end else if (pok && |req_valid) begin
      arb_at[m] = cyc + 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_ready = rdy[sel]; s_en = en[sel]; s_data = dout[sel];
    s_gid = gid[sel]; s_busy = bsy[sel]; s_abort = abt[sel];
    for (int m = 0; m < 2; m++) model_step(m);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = on[i] && (pos[i] < total[i]);
      req_data[8*i +: 8] = 8'(16*i + pos[i] + 1);
      req_last[i] = (pkt[i] != 0) && ((pos[i] % pkt[i]) == pkt[i] - 1);
    end
  endtask

  task automatic tick();
    drive_src();
    cycle();
    for (int i = 0; i < N; i++)
      if (s_ready[i] && req_valid[i]) begin pos[i]++; acc.push_back(cyc); end
    if (s_en) begin oc.push_back(cyc); od.push_back(s_data); end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_en"}, m, 32'(en[m]), 0);
      chk({tag, "_data"}, m, 32'(dout[m]), 0);
      chk({tag, "_gid"}, m, 32'(gid[m]), N - 1);
      chk({tag, "_busy"}, m, 32'(bsy[m]), 0);
      chk({tag, "_abort"}, m, 32'(abt[m]), 0);
      chk({tag, "_ready"}, m, 32'(rdy[m]), 0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    phase = 3'd4; ll_ready = 1'b1; req_valid = '0; req_last = '0; req_data = '0; stats_clr = 1'b0;
    for (int i = 0; i < N; i++) begin on[i] = 1'b0; pos[i] = 0; pkt[i] = 0; total[i] = 0; end
    oc.delete(); od.delete(); acc.delete();
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs_own [$], bs_first [$], bs_last [$];
    logic [7:0] exp_cap [12];
    logic [7:0] b;
    int waited;

    tbl[0]  = '{3'd4, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3};
    tbl[1]  = '{3'd4, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3};
    tbl[2]  = '{3'd4, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[3]  = '{3'd4, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd0};
    tbl[4]  = '{3'd4, 1'b1, 8'hAC, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b1, 2'd0};
    tbl[5]  = '{3'd4, 1'b1, 8'hAD, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAC, 1'b1, 2'd0};
    tbl[6]  = '{3'd4, 1'b1, 8'hAE, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAD, 1'b1, 2'd0};
    tbl[7]  = '{3'd4, 1'b0, 8'hAE, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAE, 1'b1, 2'd0};
    tbl[8]  = '{3'd4, 1'b0, 8'hAE, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAE, 1'b1, 2'd0};
    tbl[9]  = '{3'd4, 1'b0, 8'hAE, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAE, 1'b1, 2'd0};
    tbl[10] = '{3'd4, 1'b0, 8'hAE, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAE, 1'b0, 2'd0};

    // Single requester, 5-byte packet.
    sel = 0;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      phase = tbl[i].ph; ll_ready = tbl[i].ll;
      req_valid = {3'b000, tbl[i].v}; req_data = '0; req_data[7:0] = tbl[i].d;
      req_last = {3'b000, tbl[i].l};
      cycle();
      chk($sformatf("tbl%0d_ready", i), 0, 32'(s_ready[0]), 32'(tbl[i].e_r));
      chk($sformatf("tbl%0d_en", i), 0, 32'(s_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_data", i), 0, 32'(s_data), 32'(tbl[i].e_d));
      chk($sformatf("tbl%0d_busy", i), 0, 32'(s_busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_gid", i), 0, 32'(s_gid), 32'(tbl[i].e_gid));
    end

    // Round-robin with 2-byte packets from every requester.
    apply_reset();
    for (int i = 0; i < N; i++) begin on[i] = 1'b1; pkt[i] = 2; total[i] = 100; end
    repeat (40) tick();
    for (int i = 0; i < oc.size(); i++) begin
      if (i == 0 || oc[i] != oc[i-1] + 1) begin
        b = od[i];
        bs_own.push_back(int'(b[7:4])); bs_first.push_back(oc[i]);
        if (i > 0) bs_last.push_back(oc[i-1]);
      end
    end
    if (oc.size() > 0) bs_last.push_back(oc[oc.size()-1]);
    chk("rr_enough_bursts", 0, 32'(bs_own.size() >= 5), 1);
    if (bs_own.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_owner%0d", k), 0, bs_own[k], k % N);
        chk($sformatf("rr_len%0d", k), 0, bs_last[k] - bs_first[k] + 1, 2);
        if (k < 4) chk($sformatf("rr_idle%0d", k), 0, bs_first[k+1] - bs_last[k] - 1, 3);
      end
    end

    // Burst cap of 4 on the second instance.
    sel = 1;
    apply_reset();
    on[1] = 1'b1; pkt[1] = 0; total[1] = 10;
    on[2] = 1'b1; pkt[2] = 2; total[2] = 2;
    repeat (45) tick();
    exp_cap = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
    chk("cap_count", 1, od.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < od.size()) chk($sformatf("cap_byte%0d", i), 1, 32'(od[i]), 32'(exp_cap[i]));

    // Back-pressure with ll_ready toggling every cycle.
    sel = 0;
    apply_reset();
    on[0] = 1'b1; pkt[0] = 4; total[0] = 4;
    for (int t = 0; t < 20; t++) begin
      ll_ready = (t % 2 == 0);
      tick();
    end
    chk("bp_count", 0, od.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < od.size()) chk($sformatf("bp_byte%0d", i), 0, 32'(od[i]), i + 1);
      if (i < od.size() && i < acc.size()) chk($sformatf("bp_lat%0d", i), 0, oc[i] - acc[i], 1);
    end

    // Phase drop after the 3rd byte of a 6-byte packet.
    apply_reset();
    on[0] = 1'b1; pkt[0] = 6; total[0] = 6;
    waited = 0;
    while (pos[0] < 3 && waited < 20) begin tick(); waited++; end
    chk("pd_third_byte", 0, pos[0], 3);
    phase = 3'd2;
    tick();
    chk("pd_ready_same_cycle", 0, 32'(s_ready), 0);
    chk("pd_abort_not_yet", 0, 32'(s_abort), 0);
    tick();
    chk("pd_abort_pulse", 0, 32'(s_abort), 1);
    chk("pd_idle", 0, 32'(s_busy), 0);
    tick();
    chk("pd_abort_one_cycle", 0, 32'(s_abort), 0);
    phase = 3'd4;
    on[1] = 1'b1; pkt[1] = 2; total[1] = 2;
    waited = 0;
    do begin tick(); waited++; end while (!s_en && waited < 20);
    chk("pd_resume_seen", 0, 32'(s_en), 1);
    chk("pd_resume_owner", 0, 32'(s_data[7:4]), 1);
    chk("pd_resume_gid", 0, 32'(s_gid), 1);

    // Asynchronous reset in the middle of a burst.
    apply_reset();
    on[0] = 1'b1; pkt[0] = 0; total[0] = 50;
    repeat (6) tick();
    chk("mid_burst_active", 0, 32'(en[0]), 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");

    // Randomized traffic against the reference model.
    sel = 0;
    apply_reset();
    repeat (3000) begin
      phase = ($urandom_range(0, 19) != 0) ? 3'd4 : 3'($urandom_range(0, 7));
      ll_ready = ($urandom_range(0, 3) != 0);
      req_valid = N'($urandom);
      req_data = ($urandom);
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 5) == 0);
      cycle();
    end

`ifdef UL_ARB_STATS_EN
    begin
      int cnt;
      int guard;
      apply_reset();
      req_valid = 4'b1000; req_data = '0; req_last = '0;
      cnt = 0; guard = 0;
      while (cnt < 32'h10005 && guard < 90000) begin
        @(negedge clk);
        if (rdy[0][3]) cnt++;
        guard++;
        @(posedge clk); #1;
      end
      req_valid = '0;
      chk("stats_sent", 0, cnt, 32'h10005);
      repeat (3) @(posedge clk);
      #1;
      chk("stats_sat3", 0, 32'(bc[0][63:48]), 32'hFFFF);
      chk("stats_req0", 0, 32'(bc[0][15:0]), 0);
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      chk("stats_clr3", 0, 32'(bc[0][63:48]), 0);
      apply_reset();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
